// File: rtl/fusion_pkg.sv
// fusion_pkg: shared sizes, coefficient address map and FSM encoding for the decompressor.
// Rev 1.0
`default_nettype none

package fusion_pkg;
   localparam int BIT_WIDTH  = 16;
   localparam int ACC_WIDTH  = 40;
   localparam int IN_SIZE    = 128;
   localparam int OUT_SIZE   = 96;
   localparam int LANES      = 8;
   localparam int FRAC_BITS  = 8;
   localparam int STEPS      = IN_SIZE / LANES;
   localparam int BANK_DEPTH = OUT_SIZE * STEPS;
   localparam int ADDR_WIDTH = 14;
   localparam int BIAS_BASE  = 12288;
   localparam int ADDR_LIMIT = 12384;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } decomp_state_e;
endpackage

`default_nettype wire

// File: rtl/fusion_decompressor_if.sv
// fusion_decompressor_if: tensor handshakes plus coefficient write port.
// Rev 1.0
`default_nettype none

interface fusion_decompressor_if;
   import fusion_pkg::*;

   logic                            in_valid;
   logic                            in_ready;
   logic [IN_SIZE*BIT_WIDTH-1:0]    fused_tensor;
   logic                            out_valid;
   logic                            out_ready;
   logic [OUT_SIZE*BIT_WIDTH-1:0]   raw_tensor;
   logic                            busy;
   logic                            w_we;
   logic [ADDR_WIDTH-1:0]           w_addr;
   logic [BIT_WIDTH-1:0]            w_data;
   logic                            w_err;

   modport master (
      output in_valid, fused_tensor, out_ready, w_we, w_addr, w_data,
      input  in_ready, out_valid, raw_tensor, busy, w_err
   );

   modport slave (
      input  in_valid, fused_tensor, out_ready, w_we, w_addr, w_data,
      output in_ready, out_valid, raw_tensor, busy, w_err
   );
endinterface

`default_nettype wire

// File: rtl/fusion_requant.sv
// fusion_requant: 40-bit accumulator -> 16-bit via >>> FRAC_BITS and signed saturation.
// Rev 1.0 -- FUSION_DECOMP_ROUND_EN selects round-half-up instead of floor.
`default_nettype none

module fusion_requant
   import fusion_pkg::*;
(
   input  logic signed [ACC_WIDTH-1:0] acc,
   output logic signed [BIT_WIDTH-1:0] result
);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (BIT_WIDTH - 1) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (BIT_WIDTH - 1)));

   logic signed [ACC_WIDTH-1:0] biased;
   logic signed [ACC_WIDTH-1:0] shifted;

`ifdef FUSION_DECOMP_ROUND_EN
   localparam logic signed [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(2 ** (FRAC_BITS - 1));
   assign biased = acc + HALF_LSB;
`else
   assign biased = acc;
`endif

   assign shifted = biased >>> FRAC_BITS;

   always_comb begin
      result = shifted[BIT_WIDTH-1:0];
      if (shifted > SAT_MAX)
         result = SAT_MAX[BIT_WIDTH-1:0];
      else if (shifted < SAT_MIN)
         result = SAT_MIN[BIT_WIDTH-1:0];
   end
endmodule

`default_nettype wire

// File: rtl/fusion_decompressor.sv
// fusion_decompressor: 96x128 linear layer + bias, LANES MACs/cycle, 1536-cycle compute.
// Rev 1.0 -- rounding mode selected by FUSION_DECOMP_ROUND_EN inside fusion_requant.
`default_nettype none

module fusion_decompressor
   import fusion_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   fusion_decompressor_if.slave  bus
);
   localparam int O_W     = $clog2(OUT_SIZE);
   localparam int S_W     = $clog2(STEPS);
   localparam int LANE_W  = $clog2(LANES);
   localparam int BANK_AW = $clog2(BANK_DEPTH);
   localparam logic [O_W-1:0] O_LAST = O_W'(OUT_SIZE - 1);
   localparam logic [S_W-1:0] S_LAST = S_W'(STEPS - 1);

   decomp_state_e                   state;
   logic [IN_SIZE*BIT_WIDTH-1:0]    in_reg;
   logic [OUT_SIZE*BIT_WIDTH-1:0]   raw_q;
   logic [O_W-1:0]                  o_cnt;
   logic [S_W-1:0]                  s_cnt;
   logic signed [ACC_WIDTH-1:0]     acc;
   logic signed [ACC_WIDTH-1:0]     sum;
   logic signed [BIT_WIDTH-1:0]     req;
   logic                            in_ready_q;
   logic                            out_valid_q;
   logic                            busy_q;
   logic                            w_err_q;

   logic                            wr_ok;
   logic                            wt_we;
   logic                            bias_we;
   logic [LANE_W-1:0]               wr_lane;
   logic [BANK_AW-1:0]              wr_idx;
   logic [O_W-1:0]                  bias_idx;
   logic [BANK_AW-1:0]              rd_idx;
   logic [LANES*BIT_WIDTH-1:0]      in_step;
   logic signed [2*BIT_WIDTH-1:0]   prod [LANES];
   logic signed [BIT_WIDTH-1:0]     bias_mem [OUT_SIZE];

   assign wr_ok    = bus.w_we && (state == IDLE) && (bus.w_addr < ADDR_WIDTH'(ADDR_LIMIT));
   assign wt_we    = wr_ok && (bus.w_addr < ADDR_WIDTH'(BIAS_BASE));
   assign bias_we  = wr_ok && (bus.w_addr >= ADDR_WIDTH'(BIAS_BASE));
   assign wr_lane  = bus.w_addr[LANE_W-1:0];
   assign wr_idx   = BANK_AW'(bus.w_addr >> LANE_W);
   assign bias_idx = O_W'(bus.w_addr - ADDR_WIDTH'(BIAS_BASE));

   // Weight i of row o lives in bank i%LANES at row o*STEPS + i/LANES.
   assign rd_idx  = BANK_AW'(o_cnt * STEPS + s_cnt);
   assign in_step = in_reg[s_cnt*LANES*BIT_WIDTH +: LANES*BIT_WIDTH];

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_bank
         logic signed [BIT_WIDTH-1:0] mem [BANK_DEPTH];

         always_ff @(posedge clk) begin
            if (wt_we && (wr_lane == LANE_W'(k)))
               mem[wr_idx] <= bus.w_data;
         end

         assign prod[k] = $signed(in_step[k*BIT_WIDTH +: BIT_WIDTH]) * mem[rd_idx];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (bias_we)
         bias_mem[bias_idx] <= bus.w_data;
   end

   always_comb begin
      sum = (s_cnt == '0) ? (ACC_WIDTH'(bias_mem[o_cnt]) <<< FRAC_BITS) : acc;
      for (int k = 0; k < LANES; k++)
         sum = sum + ACC_WIDTH'(prod[k]);
   end

   fusion_requant u_requant (
      .acc    (sum),
      .result (req)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         w_err_q     <= 1'b0;
         raw_q       <= '0;
         in_reg      <= '0;
         o_cnt       <= '0;
         s_cnt       <= '0;
         acc         <= '0;
      end else begin
         w_err_q <= bus.w_we && !wr_ok;
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  in_reg     <= bus.fused_tensor;
                  state      <= COMPUTE;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  o_cnt      <= '0;
                  s_cnt      <= '0;
                  acc        <= '0;
               end
            end
            COMPUTE: begin
               if (s_cnt == S_LAST) begin
                  raw_q[o_cnt*BIT_WIDTH +: BIT_WIDTH] <= req;
                  s_cnt <= '0;
                  acc   <= '0;
                  if (o_cnt == O_LAST) begin
                     o_cnt       <= '0;
                     state       <= OUTPUT;
                     out_valid_q <= 1'b1;
                  end else begin
                     o_cnt <= o_cnt + 1'b1;
                  end
               end else begin
                  acc   <= sum;
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.w_err      = w_err_q;
   assign bus.raw_tensor = raw_q;
endmodule

`default_nettype wire

// File: tb/tb_fusion_decompressor.sv
// tb_fusion_decompressor: directed self-checking bench for fusion_decompressor.
// Rev 1.0 -- expectations follow FUSION_DECOMP_ROUND_EN when defined.
`default_nettype none

module tb_fusion_decompressor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fusion_decompressor_if bus();

   fusion_decompressor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [15:0]   golden [96];
   logic [2047:0] fv;
   logic [1535:0] snap;
   int            cyc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic wr(input int addr, input logic [15:0] data);
      bus.w_we   = 1'b1;
      bus.w_addr = 14'(addr);
      bus.w_data = data;
      @(posedge clk); #1;
      bus.w_we   = 1'b0;
   endtask

   task automatic start(input logic [2047:0] v);
      bus.fused_tensor = v;
      bus.in_valid     = 1'b1;
      @(posedge clk); #1;
      bus.in_valid     = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.out_valid && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_within_bound", bus.out_valid, 1);
   endtask

   task automatic check_all(input string tag);
      for (int o = 0; o < 96; o++)
         chk($sformatf("%s_raw%0d", tag, o), bus.raw_tensor[o*16 +: 16], golden[o]);
   endtask

   task automatic handoff(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_ov_drop"}, bus.out_valid, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      bus.in_valid = 0; bus.out_ready = 0; bus.fused_tensor = '0;
      bus.w_we = 0; bus.w_addr = '0; bus.w_data = '0;

      // reset
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_w_err", bus.w_err, 0);
      chk("rst_raw_zero", (bus.raw_tensor === '0), 1);

      // identity weights, zero bias
      for (int a = 0; a < 12384; a++) begin
         bus.w_we   = 1'b1;
         bus.w_addr = 14'(a);
         bus.w_data = (a < 12288 && (a / 128) == (a % 128)) ? 16'd256 : 16'd0;
         @(posedge clk); #1;
      end
      bus.w_we = 1'b0;
      chk("load_no_err", bus.w_err, 0);

      // identity run with latency and backpressure
      for (int i = 0; i < 128; i++) fv[i*16 +: 16] = 16'(10 * i);
      for (int o = 0; o < 96; o++) golden[o] = 16'(10 * o);
      start(fv);
      chk("acc_busy", bus.busy, 1);
      chk("acc_in_ready", bus.in_ready, 0);
      chk("acc_out_valid", bus.out_valid, 0);
      wait_done(cyc);
      chk("latency", cyc, 1536);
      check_all("ident");
      snap = bus.raw_tensor;
      for (int c = 0; c < 20; c++) begin
         bus.in_valid = (c == 5);
         bus.fused_tensor = ~fv;
         @(posedge clk); #1;
         chk($sformatf("bp_ov_%0d", c), bus.out_valid, 1);
         chk($sformatf("bp_in_ready_%0d", c), bus.in_ready, 0);
         chk($sformatf("bp_raw_%0d", c), (bus.raw_tensor === snap), 1);
      end
      bus.in_valid = 1'b0;
      chk("bp_busy", bus.busy, 1);
      handoff("h1");

      // dropped write during compute
      for (int i = 0; i < 128; i++) fv[i*16 +: 16] = 16'(1000 - 37 * i);
      for (int o = 0; o < 96; o++) golden[o] = 16'(1000 - 37 * o);
      start(fv);
      repeat (10) @(posedge clk);
      #1;
      wr(645, 16'd999);
      chk("cmp_wr_err_pulse", bus.w_err, 1);
      @(posedge clk); #1;
      chk("cmp_wr_err_clear", bus.w_err, 0);
      wait_done(cyc);
      check_all("wrdrop");
      handoff("h2");

      // out-of-range write in IDLE
      wr(12384, 16'h1234);
      chk("oob_err_pulse", bus.w_err, 1);
      @(posedge clk); #1;
      chk("oob_err_clear", bus.w_err, 0);

      // reset abort mid-compute
      for (int i = 0; i < 128; i++) fv[i*16 +: 16] = 16'(i * i - 5000);
      for (int o = 0; o < 96; o++) golden[o] = 16'(o * o - 5000);
      start(fv);
      repeat (700) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ov", bus.out_valid, 0);
      chk("abort_raw_zero", (bus.raw_tensor === '0), 1);
      chk("abort_busy", bus.busy, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", bus.in_ready, 1);
      chk("abort_ov_after", bus.out_valid, 0);
      start(fv);
      wait_done(cyc);
      chk("latency_after_abort", cyc, 1536);
      check_all("rerun");
      handoff("h3");

      // saturation: row 0 all 256, row 1 zero with bias -5
      for (int a = 1; a < 128; a++) wr(a, 16'd256);
      wr(129, 16'd0);
      wr(12289, 16'hFFFB);
      for (int i = 0; i < 128; i++) fv[i*16 +: 16] = 16'h7FFF;
      for (int o = 0; o < 96; o++) golden[o] = 16'h7FFF;
      golden[1] = 16'hFFFB;
      start(fv);
      wait_done(cyc);
      check_all("satpos");
      handoff("h4");
      for (int i = 0; i < 128; i++) fv[i*16 +: 16] = 16'h8000;
      for (int o = 0; o < 96; o++) golden[o] = 16'h8000;
      golden[1] = 16'hFFFB;
      start(fv);
      wait_done(cyc);
      check_all("satneg");
      handoff("h5");

      // rounding: W[0][0]=0.5, single nonzero input
      wr(0, 16'd128);
      for (int a = 1; a < 128; a++) wr(a, 16'd0);
      fv = '0;
      fv[15:0] = 16'h0001;
      for (int o = 0; o < 96; o++) golden[o] = 16'h0000;
      golden[1] = 16'hFFFB;
`ifdef FUSION_DECOMP_ROUND_EN
      golden[0] = 16'h0001;
`else
      golden[0] = 16'h0000;
`endif
      start(fv);
      wait_done(cyc);
      check_all("rndpos");
      handoff("h6");
      fv[15:0] = 16'hFFFF;
`ifdef FUSION_DECOMP_ROUND_EN
      golden[0] = 16'h0000;
`else
      golden[0] = 16'hFFFF;
`endif
      start(fv);
      wait_done(cyc);
      check_all("rndneg");
      handoff("h7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
